// File: rtl/lsu_pkg.sv
// ============================================================================
// Module      : lsu_pkg
// Description : Shared definitions for the load/store unit: opcodes, fault
//               codes, FSM state type and access-size helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  // Primary opcodes handled by the LSU
  localparam logic [5:0] OP_LWZ = 6'd32;
  localparam logic [5:0] OP_LBZ = 6'd34;
  localparam logic [5:0] OP_STW = 6'd36;
  localparam logic [5:0] OP_STB = 6'd38;
  localparam logic [5:0] OP_LHZ = 6'd40;
  localparam logic [5:0] OP_LHA = 6'd42;
  localparam logic [5:0] OP_STH = 6'd44;

  // Completion fault codes
  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;
  localparam logic [1:0] FAULT_MISALIGN = 2'b11;

  // Access sizes as log2(bytes)
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  function automatic logic op_is_load(input logic [5:0] op);
    return (op == OP_LWZ) || (op == OP_LBZ) || (op == OP_LHZ) || (op == OP_LHA);
  endfunction

  function automatic logic op_is_store(input logic [5:0] op);
    return (op == OP_STW) || (op == OP_STB) || (op == OP_STH);
  endfunction

  // log2 of the access width in bytes; illegal opcodes report byte size
  function automatic logic [1:0] access_size(input logic [5:0] op);
    logic [1:0] sz;
    case (op)
      OP_LWZ, OP_STW:         sz = SIZE_WORD;
      OP_LHZ, OP_LHA, OP_STH: sz = SIZE_HALF;
      default:                sz = SIZE_BYTE;
    endcase
    return sz;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_format.sv
// ============================================================================
// Module      : lsu_load_format
// Description : Combinational load result formatter. Zero-extends byte,
//               half and word loads; sign-extends halfword algebraic loads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_load_format
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [5:0]      opcode,
  input  logic [XLEN-1:0] raw_data,
  output logic [XLEN-1:0] result
);

  // Select and extend the addressed field according to the load flavour
  always_comb begin
    result = '0;
    case (opcode)
      OP_LBZ:  result = {{(XLEN-8){1'b0}}, raw_data[7:0]};
      OP_LHZ:  result = {{(XLEN-16){1'b0}}, raw_data[15:0]};
      OP_LHA:  result = {{(XLEN-16){raw_data[15]}}, raw_data[15:0]};
      OP_LWZ:  result = {{(XLEN-32){1'b0}}, raw_data[31:0]};
      default: result = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module      : load_store_unit
// Description : Data-memory initiator. Accepts one load/store from EX,
//               computes the effective address, strobes memory until ack or
//               timeout, and returns a one-cycle formatted completion.
//               Optional macro LSU_ALIGN_CHECK_EN enables misalignment faults.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [5:0]      req_opcode,
  input  logic [XLEN-1:0] req_base,
  input  logic [15:0]     req_disp,
  input  logic [XLEN-1:0] req_store_data,
  input  logic [4:0]      req_rt,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_write_data,
  output logic [5:0]      mem_opcode,
  output logic            MemRead,
  output logic            MemWrite,
  input  logic [XLEN-1:0] mem_read_data,
  input  logic            mem_ack,
  output logic            resp_valid,
  output logic            resp_is_load,
  output logic [XLEN-1:0] resp_data,
  output logic [4:0]      resp_rt,
  output logic [1:0]      resp_fault
);

  // Counter just wide enough to reach TIMEOUT_CYCLES-1
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  lsu_state_e      state, next_state;

  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [5:0]      op_q;
  logic [4:0]      rt_q;
  logic            is_load_q;
  logic [1:0]      fault_q;
  logic [XLEN-1:0] rdata_q;
  logic [CW-1:0]   tcnt;

  logic [XLEN-1:0] ea;
  logic            accept;
  logic            legal;
  logic            misaligned;
  logic            timeout_hit;
  logic [XLEN-1:0] load_fmt;

  assign ea     = req_base + {{(XLEN-16){req_disp[15]}}, req_disp};
  assign accept = req_valid && req_ready;
  assign legal  = op_is_load(req_opcode) || op_is_store(req_opcode);

`ifdef LSU_ALIGN_CHECK_EN
  // Word accesses need EA[1:0]==0, halfword accesses need EA[0]==0
  always_comb begin
    misaligned = 1'b0;
    case (access_size(req_opcode))
      SIZE_WORD: misaligned = (ea[1:0] != 2'b00);
      SIZE_HALF: misaligned = ea[0];
      default:   misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  // An ack in the final allowed cycle takes priority over the timeout
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt == CNT_LAST) && !mem_ack;

  lsu_load_format #(
    .XLEN(XLEN)
  ) u_load_format (
    .opcode  (op_q),
    .raw_data(mem_read_data),
    .result  (load_fmt)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state selection: faults detected at accept skip the memory phase
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!legal || misaligned) next_state = RESP;
          else                      next_state = REQ;
        end
      end
      REQ: begin
        if (mem_ack || timeout_hit) next_state = RESP;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request capture, timeout counting and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      op_q      <= '0;
      rt_q      <= '0;
      is_load_q <= 1'b0;
      fault_q   <= FAULT_NONE;
      rdata_q   <= '0;
      tcnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q    <= ea;
            wdata_q   <= req_store_data;
            op_q      <= req_opcode;
            rt_q      <= req_rt;
            is_load_q <= op_is_load(req_opcode);
            rdata_q   <= '0;
            tcnt      <= '0;
            if (!legal)          fault_q <= FAULT_ILLEGAL;
            else if (misaligned) fault_q <= FAULT_MISALIGN;
            else                 fault_q <= FAULT_NONE;
          end
        end
        REQ: begin
          if (mem_ack) begin
            rdata_q <= is_load_q ? load_fmt : '0;
          end else if (timeout_hit) begin
            fault_q <= FAULT_TIMEOUT;
            rdata_q <= '0;
          end else begin
            tcnt <= tcnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready      = (state == IDLE);
  assign MemRead        = (state == REQ) && is_load_q;
  assign MemWrite       = (state == REQ) && !is_load_q;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_opcode     = op_q;

  // Completion fields are only driven during the single response cycle
  assign resp_valid   = (state == RESP);
  assign resp_is_load = resp_valid && is_load_q && (fault_q == FAULT_NONE);
  assign resp_data    = resp_valid ? rdata_q : '0;
  assign resp_rt      = resp_valid ? rt_q : '0;
  assign resp_fault   = resp_valid ? fault_q : FAULT_NONE;

endmodule

`default_nettype wire
